inst_fetch: RTL and testbench

Instruction fetch unit feeding the processor core's `instruction` input. Maintains the program counter, issues reads to a synchronous instruction memory (1-cycle read latency), and buffers returned 16-bit instructions in a 2-entry FIFO presented to the core over a valid/ready handshake. Supports control-flow redirects (branch/jump) with flush of buffered and in-flight fetches, plus a halt input that stops issue.

---
 rtl/inst_fetch.sv | 90 +++++++++
 tb/tb_inst_fetch.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch unit: PC sequencing, 1-cycle synchronous imem reads and a
// 2-entry instruction FIFO to the core, with epoch-tagged redirect flush and halt.
module inst_fetch #(
    parameter int              PC_W     = 10,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_en,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_rdata,
    output logic [15:0]     instruction,
    output logic [PC_W-1:0] inst_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            halt
);

    logic [PC_W-1:0] r_pc;
    logic [1:0]      r_count;
    logic            r_epoch;
    logic            r_inflight_p1;
    logic            r_inf_epoch_p1;
    logic [PC_W-1:0] r_inf_pc_p1;
    logic [15:0]     r_data [2];
    logic [PC_W-1:0] r_dpc  [2];

    logic            w_pop;
    logic            w_push;
    logic            w_issue;
    logic            w_slot;
    logic [2:0]      w_occ;

    assign w_pop   = (r_count != 2'd0) && inst_ready;
    // Credit: entries held plus the read in flight, less what leaves this cycle.
    assign w_occ   = {1'b0, r_count} + {2'b00, r_inflight_p1} - {2'b00, w_pop};
    assign w_issue = rst && !halt && !redirect && (w_occ < 3'd2);
    assign w_push  = r_inflight_p1 && (r_inf_epoch_p1 == r_epoch) && !redirect;
    assign w_slot  = (r_count == 2'd2) || ((r_count == 2'd1) && !w_pop);

    // Issue stage -> return stage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc           <= RESET_PC;
            r_count        <= 2'd0;
            r_epoch        <= 1'b0;
            r_inflight_p1  <= 1'b0;
            r_inf_epoch_p1 <= 1'b0;
        end else begin
            r_inflight_p1 <= w_issue;
            if (w_issue) begin
                r_inf_epoch_p1 <= r_epoch;
            end
            if (redirect) begin
                r_pc    <= redirect_pc;
                r_epoch <= ~r_epoch;
                r_count <= 2'd0;
            end else begin
                if (w_issue) begin
                    r_pc <= r_pc + 1'b1;
                end
                r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
            end
        end
    end

    // Return stage -> FIFO
    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_inf_pc_p1 <= r_pc;
        end
        if (w_pop && (r_count == 2'd2)) begin
            r_data[0] <= r_data[1];
            r_dpc[0]  <= r_dpc[1];
        end
        if (w_push) begin
            r_data[w_slot] <= imem_rdata;
            r_dpc[w_slot]  <= r_inf_pc_p1;
        end
    end

    assign inst_valid  = (r_count != 2'd0);
    assign instruction = inst_valid ? r_data[0] : 16'h0000;
    assign inst_pc     = inst_valid ? r_dpc[0] : '0;
    assign imem_en     = w_issue;
    assign imem_addr   = w_issue ? r_pc : '0;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus a randomized run
// scored against an in-order delivery model of the fetch stream.
module tb_inst_fetch;

    localparam int              PC_W     = 10;
    localparam logic [PC_W-1:0] RESET_PC = '0;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            imem_en;
    logic [PC_W-1:0] imem_addr;
    logic [15:0]     imem_rdata = 16'h0000;
    logic [15:0]     instruction;
    logic [PC_W-1:0] inst_pc;
    logic            inst_valid;
    logic            inst_ready = 1'b0;
    logic            redirect = 1'b0;
    logic [PC_W-1:0] redirect_pc = '0;
    logic            halt = 1'b0;

    logic [15:0] mem [0:1023];
    int n_cmp = 0;
    int n_err = 0;

    inst_fetch #(.PC_W(PC_W), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .imem_en(imem_en), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .instruction(instruction), .inst_pc(inst_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .redirect(redirect),
        .redirect_pc(redirect_pc), .halt(halt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem[imem_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic restart();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        tick();
        tick();
        #1;
        n_cmp++; if (imem_en !== 1'b0) begin n_err++; $display("FAIL reset_en: got %0b want 0", imem_en); end
        n_cmp++; if (imem_addr !== '0) begin n_err++; $display("FAIL reset_addr: got %0h want 0", imem_addr); end
        n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b want 0", inst_valid); end
        n_cmp++; if (instruction !== 16'h0000) begin n_err++; $display("FAIL reset_instr: got %0h want 0", instruction); end
        n_cmp++; if (inst_pc !== '0) begin n_err++; $display("FAIL reset_pc: got %0h want 0", inst_pc); end
    endtask

    task automatic test_stream();
        logic [15:0] exp_d [3];
        exp_d[0] = 16'h4142; exp_d[1] = 16'h4302; exp_d[2] = 16'h0051;
        inst_ready = 1'b1; halt = 1'b0; redirect = 1'b0;
        restart();
        for (int c = 0; c < 5; c++) begin
            #1;
            if (c < 3) begin
                n_cmp++; if (imem_en !== 1'b1) begin n_err++; $display("FAIL stream_en c%0d: got %0b want 1", c, imem_en); end
                n_cmp++; if (imem_addr !== PC_W'(c)) begin n_err++; $display("FAIL stream_addr c%0d: got %0h want %0h", c, imem_addr, c); end
            end
            n_cmp++; if (inst_valid !== (c >= 2)) begin n_err++; $display("FAIL stream_valid c%0d: got %0b want %0b", c, inst_valid, c >= 2); end
            if (c >= 2) begin
                n_cmp++; if (instruction !== exp_d[c-2]) begin n_err++; $display("FAIL stream_instr c%0d: got %0h want %0h", c, instruction, exp_d[c-2]); end
                n_cmp++; if (inst_pc !== PC_W'(c-2)) begin n_err++; $display("FAIL stream_pc c%0d: got %0h want %0h", c, inst_pc, c-2); end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int exp;
        inst_ready = 1'b0;
        restart();
        for (int c = 0; c < 7; c++) begin
            #1;
            n_cmp++; if (imem_en !== (c < 2)) begin n_err++; $display("FAIL bp_en c%0d: got %0b want %0b", c, imem_en, c < 2); end
            if (c >= 2) begin
                n_cmp++; if (inst_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid c%0d: got %0b want 1", c, inst_valid); end
                n_cmp++; if (instruction !== 16'h4142) begin n_err++; $display("FAIL bp_hold c%0d: got %0h want 4142", c, instruction); end
            end
            tick();
        end
        inst_ready = 1'b1;
        exp = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (inst_valid && inst_ready) begin
                n_cmp++; if (inst_pc !== PC_W'(exp)) begin n_err++; $display("FAIL bp_order: got pc %0h want %0h", inst_pc, exp); end
                n_cmp++; if (instruction !== mem[exp]) begin n_err++; $display("FAIL bp_data pc%0h: got %0h want %0h", exp, instruction, mem[exp]); end
                exp++;
            end
            tick();
        end
        n_cmp++; if (exp !== 10) begin n_err++; $display("FAIL bp_count: got %0d want 10", exp); end
    endtask

    task automatic test_redirect();
        logic [PC_W-1:0] np;
        inst_ready = 1'b1;
        restart();
        repeat (5) tick();
        redirect = 1'b1; redirect_pc = 10'h3F0;
        #1;
        n_cmp++; if (inst_valid !== 1'b1) begin n_err++; $display("FAIL rd_xfer_valid: got %0b want 1", inst_valid); end
        n_cmp++; if (imem_en !== 1'b0) begin n_err++; $display("FAIL rd_noissue: got %0b want 0", imem_en); end
        tick();
        redirect = 1'b0;
        #1;
        n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL rd_flush: got %0b want 0", inst_valid); end
        n_cmp++; if (imem_en !== 1'b1) begin n_err++; $display("FAIL rd_en: got %0b want 1", imem_en); end
        n_cmp++; if (imem_addr !== 10'h3F0) begin n_err++; $display("FAIL rd_addr: got %0h want 3f0", imem_addr); end
        tick(); #1;
        n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL rd_stale: got %0b want 0", inst_valid); end
        for (int k = 0; k < 3; k++) begin
            tick(); #1;
            np = 10'h3F0 + PC_W'(k);
            n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== np) begin n_err++; $display("FAIL rd_pc k%0d: got %0b/%0h want 1/%0h", k, inst_valid, inst_pc, np); end
            n_cmp++; if (instruction !== mem[np]) begin n_err++; $display("FAIL rd_data k%0d: got %0h want %0h", k, instruction, mem[np]); end
        end
    endtask

    task automatic test_wrap();
        logic [PC_W-1:0] np;
        tick();
        redirect = 1'b1; redirect_pc = 10'h3FF;
        tick();
        redirect = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            tick(); #1;
            np = 10'h3FF + PC_W'(k);
            n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== np) begin n_err++; $display("FAIL wrap_pc k%0d: got %0b/%0h want 1/%0h", k, inst_valid, inst_pc, np); end
            n_cmp++; if (instruction !== mem[np]) begin n_err++; $display("FAIL wrap_data k%0d: got %0h want %0h", k, instruction, mem[np]); end
        end
    endtask

    task automatic test_halt();
        inst_ready = 1'b1; halt = 1'b0;
        restart();
        tick();
        halt = 1'b1;
        for (int c = 1; c < 7; c++) begin
            #1;
            n_cmp++; if (imem_en !== 1'b0) begin n_err++; $display("FAIL halt_en c%0d: got %0b want 0", c, imem_en); end
            n_cmp++; if (inst_valid !== (c == 2)) begin n_err++; $display("FAIL halt_valid c%0d: got %0b want %0b", c, inst_valid, c == 2); end
            if (c == 2) begin
                n_cmp++; if (inst_pc !== RESET_PC || instruction !== 16'h4142) begin n_err++; $display("FAIL halt_drain: got %0h/%0h want 0/4142", inst_pc, instruction); end
            end
            tick();
        end
        redirect = 1'b1; redirect_pc = 10'h100;
        tick();
        redirect = 1'b0;
        tick(); tick();
        #1;
        n_cmp++; if (imem_en !== 1'b0) begin n_err++; $display("FAIL halt_rd_en: got %0b want 0", imem_en); end
        halt = 1'b0;
        #1;
        n_cmp++; if (imem_en !== 1'b1 || imem_addr !== 10'h100) begin n_err++; $display("FAIL halt_resume: got %0b/%0h want 1/100", imem_en, imem_addr); end
        tick(); tick(); #1;
        n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 10'h100) begin n_err++; $display("FAIL halt_resume_pc: got %0b/%0h want 1/100", inst_valid, inst_pc); end
    endtask

    task automatic test_reset_mid();
        inst_ready = 1'b1; halt = 1'b0;
        restart();
        repeat (4) tick();
        #3 rst = 1'b0;
        #1;
        n_cmp++; if (inst_valid !== 1'b0 || imem_en !== 1'b0) begin n_err++; $display("FAIL midrst: got valid %0b en %0b want 0 0", inst_valid, imem_en); end
        n_cmp++; if (instruction !== 16'h0000) begin n_err++; $display("FAIL midrst_instr: got %0h want 0", instruction); end
        tick();
        rst = 1'b1;
        #1;
        n_cmp++; if (imem_en !== 1'b1 || imem_addr !== RESET_PC) begin n_err++; $display("FAIL midrst_restart: got %0b/%0h want 1/%0h", imem_en, imem_addr, RESET_PC); end
        tick(); tick(); #1;
        n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== RESET_PC) begin n_err++; $display("FAIL midrst_pc: got %0b/%0h want 1/%0h", inst_valid, inst_pc, RESET_PC); end
    endtask

    task automatic test_random();
        logic [PC_W-1:0] exp_pc, exp_iss;
        logic            prev_hold;
        logic [25:0]     prev_val;
        int              delivered;
        exp_pc = RESET_PC; exp_iss = RESET_PC;
        prev_hold = 1'b0; prev_val = '0; delivered = 0;
        inst_ready = 1'b1; halt = 1'b0; redirect = 1'b0;
        restart();
        for (int c = 0; c < 3000; c++) begin
            inst_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) halt = ~halt;
            redirect = ($urandom_range(0, 39) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ? PC_W'(10'h3FC + $urandom_range(0, 3)) : PC_W'($urandom);
            #1;
            if (imem_en) begin
                n_cmp++; if (halt || redirect) begin n_err++; $display("FAIL rnd_issue_blocked c%0d: en=1 halt=%0b redirect=%0b", c, halt, redirect); end
                n_cmp++; if (imem_addr !== exp_iss) begin n_err++; $display("FAIL rnd_issue_addr c%0d: got %0h want %0h", c, imem_addr, exp_iss); end
                exp_iss = exp_iss + 1'b1;
            end
            if (prev_hold) begin
                n_cmp++; if (!inst_valid || {inst_pc, instruction} !== prev_val) begin n_err++; $display("FAIL rnd_stable c%0d: got %0b/%0h want 1/%0h", c, inst_valid, {inst_pc, instruction}, prev_val); end
            end
            if (inst_valid && inst_ready) begin
                n_cmp++; if (inst_pc !== exp_pc) begin n_err++; $display("FAIL rnd_pc c%0d: got %0h want %0h", c, inst_pc, exp_pc); end
                n_cmp++; if (instruction !== mem[exp_pc]) begin n_err++; $display("FAIL rnd_data c%0d: got %0h want %0h", c, instruction, mem[exp_pc]); end
                exp_pc = exp_pc + 1'b1;
                delivered++;
            end
            prev_hold = inst_valid && !inst_ready && !redirect;
            prev_val  = {inst_pc, instruction};
            if (redirect) begin
                exp_pc  = redirect_pc;
                exp_iss = redirect_pc;
            end
            tick();
        end
        redirect = 1'b0; halt = 1'b0;
        n_cmp++; if (delivered < 200) begin n_err++; $display("FAIL rnd_progress: got %0d deliveries want >= 200", delivered); end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h4142; mem[1] = 16'h4302; mem[2] = 16'h0051;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_halt();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
